alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the processor's single-cycle ALU: same opcode map, generic DATA_W,

---
 rtl/alu_seq_pkg.sv | 32 +++
 rtl/alu_seq_mul.sv | 76 +++++++
 rtl/alu_seq.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM states and flag bit indices shared by alu_seq
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_MUL    = 4'h2;
  localparam logic [3:0] OP_SHL    = 4'h3;
  localparam logic [3:0] OP_SHR    = 4'h4;
  localparam logic [3:0] OP_INCA   = 4'h5;
  localparam logic [3:0] OP_INCB   = 4'h6;
  localparam logic [3:0] OP_DECA   = 4'h7;
  localparam logic [3:0] OP_DECB   = 4'h8;
  localparam logic [3:0] OP_EQ     = 4'h9;
  localparam logic [3:0] OP_GT     = 4'hA;
  localparam logic [3:0] OP_LT     = 4'hB;
  localparam logic [3:0] OP_ROW    = 4'hC;
  localparam logic [3:0] OP_COL    = 4'hD;
  localparam logic [3:0] OP_NE     = 4'hE;
  localparam logic [3:0] OP_PARITY = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLAGS_W   = 3;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVFL  = 2;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one bit of b per cycle
// Ports: CLK/RESET (sync, active-high); start_i loads a_i/b_i and performs the first
// iteration; done_o pulses for one cycle once product_o holds the full 2*DATA_W product.
module alu_seq_mul #(
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  done_o,
  output logic [2*DATA_W-1:0]   product_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // The start cycle already consumes b[0], so only DATA_W-1 further cycles are
  // needed and the product is ready in the DATA_W-th cycle after start.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start_i) begin
      acc_d    = b_i[0] ? {{DATA_W{1'b0}}, a_i} : '0;
      mcand_d  = {{(DATA_W-1){1'b0}}, a_i, 1'b0};
      mplier_d = b_i >> 1;
      cnt_d    = CNT_W'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_CNT) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done_o    = done_q;
  assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative multiplier and registered result/flags
// Ports: CLK/RESET (sync, active-high); IN_VALID/IN_READY with IN_A, IN_B, ALU_Op_Code;
// OUT_VALID/OUT_READY with OUT_RESULT and OUT_FLAGS = {OVFL, CARRY, ZERO}.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ROW_SPAN = 39,
  parameter int COL_SPAN = 52
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [DATA_W-1:0]   IN_A,
  input  logic [DATA_W-1:0]   IN_B,
  input  logic [3:0]          ALU_Op_Code,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [DATA_W-1:0]   OUT_RESULT,
  output logic [FLAGS_W-1:0]  OUT_FLAGS
);

  localparam logic [DATA_W:0] ROW_SPAN_W = (DATA_W+1)'(ROW_SPAN);
  localparam logic [DATA_W:0] COL_SPAN_W = (DATA_W+1)'(COL_SPAN);
  localparam logic [DATA_W:0] ONE_W      = (DATA_W+1)'(1);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    res_q, res_d;
  logic [FLAGS_W-1:0]   flags_q, flags_d;

  logic                 in_ready;
  logic                 mul_start;
  logic                 load_alu;
  logic                 load_mul;
  logic                 mul_done;
  logic [2*DATA_W-1:0]  mul_product;

  logic                 arith_sub;
  logic [DATA_W:0]      arith_x, arith_y, arith_r;
  logic                 ovfl_add, ovfl_sub;
  logic [DATA_W:0]      win_a, win_lo;
  logic                 cmp_bit;
  logic [DATA_W-1:0]    alu_res;
  logic                 alu_carry, alu_ovfl;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, evaluated straight from the inputs so a non-multiply
  // result can be captured on the accept edge itself.
  // ---------------------------------------------------------------------------
  always_comb begin
    arith_sub = (ALU_Op_Code == OP_SUB) || (ALU_Op_Code == OP_DECA) ||
                (ALU_Op_Code == OP_DECB);
    arith_x   = ((ALU_Op_Code == OP_INCB) || (ALU_Op_Code == OP_DECB)) ?
                {1'b0, IN_B} : {1'b0, IN_A};
    arith_y   = ((ALU_Op_Code == OP_ADD) || (ALU_Op_Code == OP_SUB)) ?
                {1'b0, IN_B} : ONE_W;
    // Zero-extended operands put carry (add) or borrow (sub) in bit DATA_W.
    arith_r   = arith_sub ? (arith_x - arith_y) : (arith_x + arith_y);
    ovfl_add  = (arith_x[DATA_W-1] == arith_y[DATA_W-1]) &&
                (arith_r[DATA_W-1] != arith_x[DATA_W-1]);
    ovfl_sub  = (arith_x[DATA_W-1] != arith_y[DATA_W-1]) &&
                (arith_r[DATA_W-1] != arith_x[DATA_W-1]);
    // Window bounds use one extra bit so B+SPAN never wraps.
    win_a     = {1'b0, IN_A};
    win_lo    = {1'b0, IN_B};
  end

  always_comb begin
    cmp_bit = 1'b0;
    case (ALU_Op_Code)
      OP_EQ:     cmp_bit = (IN_A == IN_B);
      OP_GT:     cmp_bit = (IN_A > IN_B);
      OP_LT:     cmp_bit = (IN_A < IN_B);
      OP_ROW:    cmp_bit = (win_a >= win_lo) && (win_a <= (win_lo + ROW_SPAN_W));
      OP_COL:    cmp_bit = (win_a >= win_lo) && (win_a <= (win_lo + COL_SPAN_W));
      OP_NE:     cmp_bit = (IN_A != IN_B);
      OP_PARITY: cmp_bit = IN_A[0] ^ IN_B[0];
      default:   cmp_bit = 1'b0;
    endcase
  end

  always_comb begin
    alu_res   = {{(DATA_W-1){1'b0}}, cmp_bit};
    alu_carry = 1'b0;
    alu_ovfl  = 1'b0;
    case (ALU_Op_Code)
      OP_ADD, OP_INCA, OP_INCB: begin
        alu_res   = arith_r[DATA_W-1:0];
        alu_carry = arith_r[DATA_W];
        alu_ovfl  = ovfl_add;
      end
      OP_SUB, OP_DECA, OP_DECB: begin
        alu_res   = arith_r[DATA_W-1:0];
        alu_carry = arith_r[DATA_W];
        alu_ovfl  = ovfl_sub;
      end
      OP_MUL: begin
        alu_res = '0;
      end
      OP_SHL: begin
        alu_res   = {IN_A[DATA_W-2:0], 1'b0};
        alu_carry = IN_A[DATA_W-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, IN_A[DATA_W-1:1]};
        alu_carry = IN_A[0];
      end
      default: begin
        alu_res = {{(DATA_W-1){1'b0}}, cmp_bit};
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  alu_seq_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .CLK       (CLK),
    .RESET     (RESET),
    .start_i   (mul_start),
    .a_i       (IN_A),
    .b_i       (IN_B),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      MUL: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // A new op may be taken in the same cycle the result is handed off.
        in_ready = OUT_READY;
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (IN_VALID && in_ready) begin
      if (ALU_Op_Code == OP_MUL) begin
        mul_start = 1'b1;
        state_d   = MUL;
      end else begin
        load_alu = 1'b1;
        state_d  = DONE;
      end
    end
  end

  always_comb begin
    res_d   = res_q;
    flags_d = flags_q;
    if (load_alu) begin
      res_d              = alu_res;
      flags_d[FLG_ZERO]  = (alu_res == '0);
      flags_d[FLG_CARRY] = alu_carry;
      flags_d[FLG_OVFL]  = alu_ovfl;
    end else if (load_mul) begin
      res_d              = mul_product[DATA_W-1:0];
      flags_d[FLG_ZERO]  = (mul_product[DATA_W-1:0] == '0);
      flags_d[FLG_CARRY] = |mul_product[2*DATA_W-1:DATA_W];
      flags_d[FLG_OVFL]  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign IN_READY   = in_ready;
  assign OUT_VALID  = (state_q == DONE);
  assign OUT_RESULT = res_q;
  assign OUT_FLAGS  = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at DATA_W=8
module tb_alu_seq;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_A;
  logic [7:0]  IN_B;
  logic [3:0]  ALU_Op_Code;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [7:0]  OUT_RESULT;
  logic [2:0]  OUT_FLAGS;

  int          checks = 0;
  int          failures = 0;
  logic [10:0] sb_q[$];
  logic [10:0] sb_exp;

  alu_seq #(
    .DATA_W   (8),
    .ROW_SPAN (39),
    .COL_SPAN (52)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_A        (IN_A),
    .IN_B        (IN_B),
    .ALU_Op_Code (ALU_Op_Code),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_RESULT  (OUT_RESULT),
    .OUT_FLAGS   (OUT_FLAGS)
  );

  always #5 CLK = ~CLK;

  // Reference: {OVFL, CARRY, ZERO, RESULT[7:0]} from integer arithmetic.
  function automatic logic [10:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    int ia, ib, sa, sb, r, s;
    logic c, v;
    logic [7:0] res;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 127) ? ia - 256 : ia;
    sb = (ib > 127) ? ib - 256 : ib;
    r = 0; s = 0; c = 1'b0; v = 1'b0;
    case (op)
      4'h0: begin r = ia + ib; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      4'h1: begin r = ia - ib; c = (r < 0);   s = sa - sb; v = (s > 127) || (s < -128); end
      4'h2: begin r = ia * ib; c = (r > 255); end
      4'h3: begin r = ia * 2;  c = (ia > 127); end
      4'h4: begin r = ia / 2;  c = (ia % 2 == 1); end
      4'h5: begin r = ia + 1;  c = (r > 255); s = sa + 1; v = (s > 127); end
      4'h6: begin r = ib + 1;  c = (r > 255); s = sb + 1; v = (s > 127); end
      4'h7: begin r = ia - 1;  c = (r < 0);   s = sa - 1; v = (s < -128); end
      4'h8: begin r = ib - 1;  c = (r < 0);   s = sb - 1; v = (s < -128); end
      4'h9: r = (ia == ib) ? 1 : 0;
      4'hA: r = (ia > ib) ? 1 : 0;
      4'hB: r = (ia < ib) ? 1 : 0;
      4'hC: r = ((ia >= ib) && (ia <= ib + 39)) ? 1 : 0;
      4'hD: r = ((ia >= ib) && (ia <= ib + 52)) ? 1 : 0;
      4'hE: r = (ia != ib) ? 1 : 0;
      default: r = ((ia % 2) != (ib % 2)) ? 1 : 0;
    endcase
    res = r[7:0];
    return {v, c, (res == 8'h00), res};
  endfunction

  // Scoreboard monitor: every handoff pops and checks the oldest expectation.
  always @(negedge CLK) begin
    if (!RESET && OUT_VALID && OUT_READY) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got result=%h flags=%b, no output expected",
                 OUT_RESULT, OUT_FLAGS);
      end else begin
        sb_exp = sb_q.pop_front();
        if ({OUT_FLAGS, OUT_RESULT} !== sb_exp) begin
          failures++;
          $display("FAIL sb_result got flags=%b result=%h expected flags=%b result=%h",
                   OUT_FLAGS, OUT_RESULT, sb_exp[10:8], sb_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Called at posedge+1 with the DUT idle or ready; returns at posedge+1 after the accept edge.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    IN_VALID    = 1'b1;
    ALU_Op_Code = op;
    IN_A        = a;
    IN_B        = b;
    sb_q.push_back(model(op, a, b));
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL send_ready op=%h got IN_READY=%b expected 1", op, IN_READY);
    end
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_A     = 8'($urandom);
    IN_B     = 8'($urandom);
  endtask

  task automatic test_reset();
    RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_A = 8'h00; IN_B = 8'h00; ALU_Op_Code = 4'h0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({IN_READY, OUT_VALID, OUT_FLAGS, OUT_RESULT} !== {1'b1, 1'b0, 3'b000, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b vld=%b flags=%b res=%h expected 1 0 000 00",
               IN_READY, OUT_VALID, OUT_FLAGS, OUT_RESULT);
    end
  endtask

  task automatic test_add_sub();
    logic [3:0]  ops[6]  = '{4'h0, 4'h0, 4'h1, 4'h8, 4'h5, 4'h3};
    logic [7:0]  as[6]   = '{8'hF0, 8'h7F, 8'h00, 8'h55, 8'hFF, 8'h81};
    logic [7:0]  bs[6]   = '{8'h20, 8'h01, 8'h01, 8'h00, 8'h12, 8'h00};
    logic [10:0] exps[6] = '{{3'b010, 8'h10}, {3'b100, 8'h80}, {3'b010, 8'hFF},
                             {3'b010, 8'hFF}, {3'b011, 8'h00}, {3'b010, 8'h02}};
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      send(ops[i], as[i], bs[i]);
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, OUT_FLAGS, OUT_RESULT} !== {1'b1, exps[i]}) begin
        failures++;
        $display("FAIL arith_%0d got vld=%b flags=%b res=%h expected 1 %b %h", i,
                 OUT_VALID, OUT_FLAGS, OUT_RESULT, exps[i][10:8], exps[i][7:0]);
      end
    end
  endtask

  task automatic test_mul();
    int n;
    int bad;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    send(4'h2, 8'h0C, 8'h0D);
    bad = 0;
    for (int k = 1; k <= 8; k++) begin
      IN_VALID    = (k < 8);
      ALU_Op_Code = 4'h0;
      @(negedge CLK);
      if (IN_READY !== 1'b0 || OUT_VALID !== 1'b0) bad++;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL mul_busy got %0d cycles with IN_READY or OUT_VALID high, expected 0", bad);
    end
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_FLAGS, OUT_RESULT} !== {1'b1, 3'b000, 8'h9C}) begin
      failures++;
      $display("FAIL mul_0c_0d got vld=%b flags=%b res=%h expected 1 000 9c",
               OUT_VALID, OUT_FLAGS, OUT_RESULT);
    end
    @(posedge CLK); #1;
    send(4'h2, 8'h10, 8'h10);
    n = 0;
    while (OUT_VALID !== 1'b1 && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n != 8 || {OUT_FLAGS, OUT_RESULT} !== {3'b011, 8'h00}) begin
      failures++;
      $display("FAIL mul_10_10 got wait=%0d flags=%b res=%h expected wait=8 011 00",
               n, OUT_FLAGS, OUT_RESULT);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
    send(4'h1, 8'h30, 8'h10);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      IN_VALID    = 1'b1;
      ALU_Op_Code = 4'h0;
      IN_A        = 8'h77;
      IN_B        = 8'h11;
      @(negedge CLK);
      if ({IN_READY, OUT_VALID, OUT_FLAGS, OUT_RESULT} !== {1'b0, 1'b1, 3'b000, 8'h20}) bad++;
      @(posedge CLK); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable got %0d unstable cycles, expected 0", bad);
    end
    OUT_READY = 1'b1;
    send(4'h0, 8'h01, 8'h01);
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_RESULT} !== {1'b1, 8'h02}) begin
      failures++;
      $display("FAIL bp_b2b got vld=%b res=%h expected 1 02", OUT_VALID, OUT_RESULT);
    end
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    send(4'h2, 8'hAB, 8'hCD);
    repeat (3) begin @(posedge CLK); #1; end
    RESET = 1'b1;
    sb_q.delete();
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({OUT_VALID, OUT_RESULT, OUT_FLAGS, IN_READY} !== {1'b0, 8'h00, 3'b000, 1'b1}) begin
      failures++;
      $display("FAIL rst_mul got vld=%b res=%h flags=%b rdy=%b expected 0 00 000 1",
               OUT_VALID, OUT_RESULT, OUT_FLAGS, IN_READY);
    end
    stale = 0;
    repeat (12) begin
      @(negedge CLK);
      if (OUT_VALID !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++;
      $display("FAIL rst_stale got %0d valid cycles after reset, expected 0", stale);
    end
  endtask

  task automatic test_window();
    logic [3:0] ops[8] = '{4'hC, 4'hC, 4'hC, 4'hD, 4'hD, 4'hF, 4'hE, 4'h4};
    logic [7:0] as[8]  = '{8'd100, 8'd101, 8'd255, 8'd113, 8'd114, 8'd3, 8'd5, 8'h03};
    logic [7:0] bs[8]  = '{8'd61, 8'd61, 8'd250, 8'd61, 8'd61, 8'd2, 8'd5, 8'h00};
    logic [10:0] exps[8] = '{{3'b000, 8'h01}, {3'b001, 8'h00}, {3'b000, 8'h01},
                             {3'b000, 8'h01}, {3'b001, 8'h00}, {3'b000, 8'h01},
                             {3'b001, 8'h00}, {3'b010, 8'h01}};
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      send(ops[i], as[i], bs[i]);
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, OUT_FLAGS, OUT_RESULT} !== {1'b1, exps[i]}) begin
        failures++;
        $display("FAIL window_%0d got vld=%b flags=%b res=%h expected 1 %b %h", i,
                 OUT_VALID, OUT_FLAGS, OUT_RESULT, exps[i][10:8], exps[i][7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] edges[4] = '{8'h00, 8'hFF, 8'h7F, 8'h80};
    int n;
    @(posedge CLK); #1;
    for (int c = 0; c < 400; c++) begin
      IN_VALID    = ($urandom_range(0, 3) != 0);
      ALU_Op_Code = 4'($urandom_range(0, 15));
      IN_A        = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
      IN_B        = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 8'($urandom);
      OUT_READY   = ($urandom_range(0, 3) != 0);
      #1;
      if (IN_VALID && IN_READY) sb_q.push_back(model(ALU_Op_Code, IN_A, IN_B));
      @(posedge CLK); #1;
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain got %0d outstanding results, expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_window();
    test_back_to_back();
    repeat (2) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
